// File: rtl/hazard_sequencer_if.sv
// Bundles the pipeline-side hazard inputs and the stall/flush/forward controls
// driven back to the 5-stage core.
interface hazard_sequencer_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic             ResultSrcE0, PCSrcE, McStartE, McDoneE, RegWriteM, RegWriteW;
  logic             StallF, StallD, StallE, FlushD, FlushE, FlushM;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             McErr;
  logic [CNT_W-1:0] StallCnt, FlushCnt;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output ResultSrcE0, PCSrcE, McStartE, McDoneE, RegWriteM, RegWriteW,
    input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
    input  ForwardAE, ForwardBE, McErr, StallCnt, FlushCnt
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  ResultSrcE0, PCSrcE, McStartE, McDoneE, RegWriteM, RegWriteW,
    output StallF, StallD, StallE, FlushD, FlushE, FlushM,
    output ForwardAE, ForwardBE, McErr, StallCnt, FlushCnt
  );
endinterface

// File: rtl/hazard_sequencer.sv
// Hazard/sequencing controller: stalls, flushes, forwarding, multi-cycle op
// tracking with timeout, and saturating stall/flush counters.
module hazard_sequencer #(
  parameter int REG_W      = 5,
  parameter int CNT_W      = 16,
  parameter int MC_TIMEOUT = 64
) (
  input logic               CLK,
  input logic               RST,
  hazard_sequencer_if.slave hif
);
  localparam int MCC_W = $clog2(MC_TIMEOUT);
  localparam logic [MCC_W-1:0] MCC_LAST = MCC_W'(MC_TIMEOUT - 1);

  typedef enum logic [1:0] {RUN, MC_WAIT} state_t;

  state_t           r_state, w_next_state;
  logic [MCC_W-1:0] r_mc_cnt;
  logic             r_mc_err;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  logic w_load_use, w_mc_clr, w_mc_inc, w_timeout, w_pc_flush;
  logic w_stall_f, w_stall_d, w_stall_e, w_flush_d, w_flush_e, w_flush_m;
  logic [1:0] w_fwd_a, w_fwd_b;

  assign w_load_use = hif.ResultSrcE0 && (hif.RdE != '0) &&
                      ((hif.RdE == hif.Rs1D) || (hif.RdE == hif.Rs2D));

  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (!RST) begin
      if (hif.RegWriteM && (hif.RdM != '0) && (hif.RdM == hif.Rs1E))      w_fwd_a = 2'b10;
      else if (hif.RegWriteW && (hif.RdW != '0) && (hif.RdW == hif.Rs1E)) w_fwd_a = 2'b01;
      if (hif.RegWriteM && (hif.RdM != '0) && (hif.RdM == hif.Rs2E))      w_fwd_b = 2'b10;
      else if (hif.RegWriteW && (hif.RdW != '0) && (hif.RdW == hif.Rs2E)) w_fwd_b = 2'b01;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_mc_clr     = 1'b0;
    w_mc_inc     = 1'b0;
    w_timeout    = 1'b0;
    w_pc_flush   = 1'b0;
    w_stall_f    = 1'b0;
    w_stall_d    = 1'b0;
    w_stall_e    = 1'b0;
    w_flush_d    = 1'b0;
    w_flush_e    = 1'b0;
    w_flush_m    = 1'b0;
    if (RST) begin
      w_flush_d    = 1'b1;
      w_flush_e    = 1'b1;
      w_flush_m    = 1'b1;
      w_next_state = RUN;
    end else begin
      case (r_state)
        RUN: begin
          if (hif.PCSrcE) begin
            w_flush_d  = 1'b1;
            w_flush_e  = 1'b1;
            w_pc_flush = 1'b1;
          end else if (hif.McStartE) begin
            w_stall_f    = 1'b1;
            w_stall_d    = 1'b1;
            w_stall_e    = 1'b1;
            w_flush_m    = 1'b1;
            w_mc_clr     = 1'b1;
            w_next_state = MC_WAIT;
          end else if (w_load_use) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_flush_e = 1'b1;
          end
        end
        MC_WAIT: begin
          if (hif.McDoneE) begin
            // Completion cycle behaves like RUN except a new McStartE is not accepted
            w_next_state = RUN;
            if (hif.PCSrcE) begin
              w_flush_d  = 1'b1;
              w_flush_e  = 1'b1;
              w_pc_flush = 1'b1;
            end else if (w_load_use) begin
              w_stall_f = 1'b1;
              w_stall_d = 1'b1;
              w_flush_e = 1'b1;
            end
          end else begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_stall_e = 1'b1;
            w_flush_m = 1'b1;
            w_mc_inc  = 1'b1;
            if (r_mc_cnt == MCC_LAST) begin
              w_timeout    = 1'b1;
              w_next_state = RUN;
            end
          end
        end
        default: w_next_state = RUN;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= RUN;
      r_mc_cnt    <= '0;
      r_mc_err    <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_mc_clr)      r_mc_cnt <= '0;
      else if (w_mc_inc) r_mc_cnt <= r_mc_cnt + 1'b1;
      if (w_timeout)     r_mc_err <= 1'b1;
      if (w_stall_f && (r_stall_cnt != '1))  r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_pc_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign hif.StallF    = w_stall_f;
  assign hif.StallD    = w_stall_d;
  assign hif.StallE    = w_stall_e;
  assign hif.FlushD    = w_flush_d;
  assign hif.FlushE    = w_flush_e;
  assign hif.FlushM    = w_flush_m;
  assign hif.ForwardAE = w_fwd_a;
  assign hif.ForwardBE = w_fwd_b;
  assign hif.McErr     = r_mc_err;
  assign hif.StallCnt  = r_stall_cnt;
  assign hif.FlushCnt  = r_flush_cnt;
endmodule
